// File: rtl/stopwatch_pkg.sv
// Shared types and digit moduli for the M:SS.t stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RUN      = 3'd1,
        STOP     = 3'd2,
        LAP_RUN  = 3'd3,
        LAP_STOP = 3'd4
    } sw_state_t;

    localparam int MOD_TENTHS = 10;
    localparam int MOD_SEC_LO = 10;
    localparam int MOD_SEC_HI = 6;
    localparam int MOD_MIN    = 10;

    typedef struct packed {
        logic [3:0] min;
        logic [2:0] sec_hi;
        logic [3:0] sec_lo;
        logic [3:0] tenths;
    } sw_time_t;

endpackage

// File: rtl/digit_cnt.sv
// Single modulo-MOD digit counter. carry is combinational so the next
// digit in the cascade advances on the same edge as this one wraps.
module digit_cnt #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             zero,
    output logic [WIDTH-1:0] out,
    output logic             carry
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

    // Digit register: clear on reset or zero, otherwise advance modulo MOD
    always_ff @(posedge clk) begin
        if (clr || zero) begin
            out <= '0;
        end else if (en) begin
            out <= (out == LAST) ? '0 : out + WIDTH'(1);
        end
    end

    assign carry = en && (out == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// M:SS.t stopwatch: prescaler, start/stop/lap/zero FSM, four-digit cascade,
// lap snapshot and sticky overflow.
// Optional build macro STOPWATCH_OVF_HALT_EN: when defined the count
// saturates at 9:59.9 and the FSM stops instead of wrapping to 0:00.0.
//
// state    | meaning
// IDLE     | zeroed, waiting for start
// RUN      | counting, display live
// STOP     | paused, display live
// LAP_RUN  | counting, display frozen on snapshot
// LAP_STOP | paused, display frozen on snapshot
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int PRESCALE = 10,
    parameter int PRE_W    = 4
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       btn_ss,
    input  logic       btn_lap,
    input  logic       btn_zero,
    output logic [3:0] disp_tenths,
    output logic [3:0] disp_sec_lo,
    output logic [2:0] disp_sec_hi,
    output logic [3:0] disp_min,
    output logic       running,
    output logic       lap_hold,
    output logic       ovf
);

`ifdef STOPWATCH_OVF_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    sw_state_t         state;
    sw_state_t         state_next;
    logic [PRE_W-1:0]  pre_cnt;
    logic              tick;
    logic              at_max;
    logic              wrap_hit;
    logic              halt_hit;
    logic              ss_ok;
    logic              enter_idle;
    logic              lap_capture;

    logic [3:0] tenths_q;
    logic [3:0] sec_lo_q;
    logic [2:0] sec_hi_q;
    logic [3:0] min_q;
    logic       en_tenths;
    logic       c_tenths;
    logic       c_sec_lo;
    logic       c_sec_hi;
    logic       c_min;

    sw_time_t live;
    sw_time_t snap;
    sw_time_t shown;

    assign running  = (state == RUN) || (state == LAP_RUN);
    assign lap_hold = (state == LAP_RUN) || (state == LAP_STOP);
    assign tick     = running && (pre_cnt == PRE_LAST);

    assign at_max = (tenths_q == 4'(MOD_TENTHS - 1)) && (sec_lo_q == 4'(MOD_SEC_LO - 1))
                 && (sec_hi_q == 3'(MOD_SEC_HI - 1)) && (min_q == 4'(MOD_MIN - 1));

    // With halt enabled the cascade is held at 9:59.9, so the min carry never
    // fires and the overflow condition must come from the terminal compare.
    assign wrap_hit = HALT_EN ? (tick && at_max) : c_min;
    assign halt_hit = HALT_EN && wrap_hit;
    assign ss_ok    = btn_ss && !(HALT_EN && ovf);
    assign en_tenths = tick && !(HALT_EN && at_max);

    assign enter_idle  = (state_next == IDLE) && (state != IDLE);
    assign lap_capture = (state == RUN) && (state_next == LAP_RUN);

    // State register
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic with ss > lap > zero priority; forced stop on halt
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (btn_ss) state_next = RUN;
            end
            RUN: begin
                if (halt_hit)     state_next = STOP;
                else if (btn_ss)  state_next = STOP;
                else if (btn_lap) state_next = LAP_RUN;
            end
            LAP_RUN: begin
                if (halt_hit)     state_next = LAP_STOP;
                else if (btn_ss)  state_next = LAP_STOP;
                else if (btn_lap) state_next = RUN;
            end
            STOP: begin
                if (ss_ok)         state_next = RUN;
                else if (btn_zero) state_next = IDLE;
            end
            LAP_STOP: begin
                if (ss_ok)         state_next = LAP_RUN;
                else if (btn_lap)  state_next = STOP;
                else if (btn_zero) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Prescaler: counts only while running so a pause keeps the partial count
    always_ff @(posedge clk) begin
        if (clr || enter_idle) begin
            pre_cnt <= '0;
        end else if (running) begin
            pre_cnt <= (pre_cnt == PRE_LAST) ? '0 : pre_cnt + PRE_W'(1);
        end
    end

    digit_cnt #(.WIDTH(4), .MOD(MOD_TENTHS)) u_tenths (
        .clk(clk), .clr(clr), .en(en_tenths), .zero(enter_idle),
        .out(tenths_q), .carry(c_tenths)
    );

    digit_cnt #(.WIDTH(4), .MOD(MOD_SEC_LO)) u_sec_lo (
        .clk(clk), .clr(clr), .en(c_tenths), .zero(enter_idle),
        .out(sec_lo_q), .carry(c_sec_lo)
    );

    digit_cnt #(.WIDTH(3), .MOD(MOD_SEC_HI)) u_sec_hi (
        .clk(clk), .clr(clr), .en(c_sec_lo), .zero(enter_idle),
        .out(sec_hi_q), .carry(c_sec_hi)
    );

    digit_cnt #(.WIDTH(4), .MOD(MOD_MIN)) u_min (
        .clk(clk), .clr(clr), .en(c_sec_hi), .zero(enter_idle),
        .out(min_q), .carry(c_min)
    );

    assign live = '{min: min_q, sec_hi: sec_hi_q, sec_lo: sec_lo_q, tenths: tenths_q};

    // Lap snapshot takes the pre-increment live value on RUN->LAP_RUN
    always_ff @(posedge clk) begin
        if (clr || enter_idle) begin
            snap <= '0;
        end else if (lap_capture) begin
            snap <= live;
        end
    end

    // Sticky overflow, cleared only by reset or returning to IDLE
    always_ff @(posedge clk) begin
        if (clr || enter_idle) begin
            ovf <= 1'b0;
        end else if (wrap_hit) begin
            ovf <= 1'b1;
        end
    end

    assign shown       = lap_hold ? snap : live;
    assign disp_tenths = shown.tenths;
    assign disp_sec_lo = shown.sec_lo;
    assign disp_sec_hi = shown.sec_hi;
    assign disp_min    = shown.min;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: one instance at PRESCALE=10 for timing,
// lap and button scenarios, one at PRESCALE=2 for the 9:59.9 wrap.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic clr = 1'b1, btn_ss = 1'b0, btn_lap = 1'b0, btn_zero = 1'b0;
    logic [3:0] disp_tenths, disp_sec_lo, disp_min;
    logic [2:0] disp_sec_hi;
    logic running, lap_hold, ovf;

    logic clr_w = 1'b1, ss_w = 1'b0, lap_w = 1'b0, zero_w = 1'b0;
    logic [3:0] w_tenths, w_sec_lo, w_min;
    logic [2:0] w_sec_hi;
    logic w_running, w_lap_hold, w_ovf;

    logic [14:0] disp, disp_w;
    logic [2:0]  stat, stat_w;
    assign disp   = {disp_min, disp_sec_hi, disp_sec_lo, disp_tenths};
    assign disp_w = {w_min, w_sec_hi, w_sec_lo, w_tenths};
    assign stat   = {running, lap_hold, ovf};
    assign stat_w = {w_running, w_lap_hold, w_ovf};

    int checks = 0;
    int failures = 0;

    stopwatch_ctrl #(.PRESCALE(10), .PRE_W(4)) dut (
        .clk(clk), .clr(clr), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_zero(btn_zero),
        .disp_tenths(disp_tenths), .disp_sec_lo(disp_sec_lo), .disp_sec_hi(disp_sec_hi),
        .disp_min(disp_min), .running(running), .lap_hold(lap_hold), .ovf(ovf)
    );

    stopwatch_ctrl #(.PRESCALE(2), .PRE_W(1)) dut_w (
        .clk(clk), .clr(clr_w), .btn_ss(ss_w), .btn_lap(lap_w), .btn_zero(zero_w),
        .disp_tenths(w_tenths), .disp_sec_lo(w_sec_lo), .disp_sec_hi(w_sec_hi),
        .disp_min(w_min), .running(w_running), .lap_hold(w_lap_hold), .ovf(w_ovf)
    );

    function automatic logic [14:0] tv(input int m, input int sh, input int sl, input int t);
        return {4'(m), 3'(sh), 4'(sl), 4'(t)};
    endfunction

    // Advance n cycles; sample/drive #1 after the rising edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse(input logic ss, input logic lap, input logic zero);
        btn_ss = ss; btn_lap = lap; btn_zero = zero;
        step(1);
        btn_ss = 1'b0; btn_lap = 1'b0; btn_zero = 1'b0;
    endtask

    task automatic pulse_w(input logic ss, input logic lap, input logic zero);
        ss_w = ss; lap_w = lap; zero_w = zero;
        step(1);
        ss_w = 1'b0; lap_w = 1'b0; zero_w = 1'b0;
    endtask

    task automatic do_reset();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1; clr_w = 1'b1;
        step(2);
        clr = 1'b0; clr_w = 1'b0;
        checks++;
        if (disp !== tv(0,0,0,0)) begin failures++; $display("FAIL reset_disp got=%h exp=%h", disp, tv(0,0,0,0)); end
        checks++;
        if (stat !== 3'b000) begin failures++; $display("FAIL reset_status got=%b exp=%b", stat, 3'b000); end
        // clr must beat a coincident start request
        clr = 1'b1; btn_ss = 1'b1;
        step(1);
        clr = 1'b0; btn_ss = 1'b0;
        checks++;
        if (stat !== 3'b000) begin failures++; $display("FAIL reset_beats_ss got=%b exp=%b", stat, 3'b000); end
        // lap ignored in IDLE
        pulse(1'b0, 1'b1, 1'b0);
        checks++;
        if (stat !== 3'b000) begin failures++; $display("FAIL idle_lap_ignored got=%b exp=%b", stat, 3'b000); end
    endtask

    task automatic test_basic_count();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);          // now cycle 1
        checks++;
        if (stat !== 3'b100) begin failures++; $display("FAIL basic_run_c1 got=%b exp=%b", stat, 3'b100); end
        step(9);                          // cycle 10
        checks++;
        if (disp !== tv(0,0,0,0)) begin failures++; $display("FAIL basic_c10 got=%h exp=%h", disp, tv(0,0,0,0)); end
        step(1);                          // cycle 11
        checks++;
        if (disp !== tv(0,0,0,1)) begin failures++; $display("FAIL basic_c11 got=%h exp=%h", disp, tv(0,0,0,1)); end
        step(90);                         // cycle 101
        checks++;
        if (disp !== tv(0,0,1,0)) begin failures++; $display("FAIL basic_c101 got=%h exp=%h", disp, tv(0,0,1,0)); end
    endtask

    task automatic test_pause_resume();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);          // cycle 1
        step(24);                         // cycle 25
        checks++;
        if (disp !== tv(0,0,0,2)) begin failures++; $display("FAIL pause_c25 got=%h exp=%h", disp, tv(0,0,0,2)); end
        pulse(1'b1, 1'b0, 1'b0);          // cycle 26
        step(14);                         // cycle 40
        checks++;
        if (disp !== tv(0,0,0,2) || stat !== 3'b000) begin
            failures++; $display("FAIL pause_frozen_c40 got=%h/%b exp=%h/%b", disp, stat, tv(0,0,0,2), 3'b000);
        end
        pulse(1'b1, 1'b0, 1'b0);          // cycle 41
        step(4);                          // cycle 45
        checks++;
        if (disp !== tv(0,0,0,2)) begin failures++; $display("FAIL resume_c45 got=%h exp=%h", disp, tv(0,0,0,2)); end
        step(1);                          // cycle 46
        checks++;
        if (disp !== tv(0,0,0,3)) begin failures++; $display("FAIL resume_c46 got=%h exp=%h", disp, tv(0,0,0,3)); end
    endtask

    task automatic test_lap_freeze();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);          // cycle 1
        step(50);                         // cycle 51, live 0:00.5
        pulse(1'b0, 1'b1, 1'b0);          // cycle 52
        checks++;
        if (disp !== tv(0,0,0,5) || stat !== 3'b110) begin
            failures++; $display("FAIL lap_enter got=%h/%b exp=%h/%b", disp, stat, tv(0,0,0,5), 3'b110);
        end
        step(68);                         // cycle 120, live 0:01.1
        checks++;
        if (disp !== tv(0,0,0,5)) begin failures++; $display("FAIL lap_hold_c120 got=%h exp=%h", disp, tv(0,0,0,5)); end
        pulse(1'b0, 1'b1, 1'b0);          // cycle 121, live 0:01.2
        checks++;
        if (disp !== tv(0,0,1,2) || stat !== 3'b100) begin
            failures++; $display("FAIL lap_exit got=%h/%b exp=%h/%b", disp, stat, tv(0,0,1,2), 3'b100);
        end
    endtask

    task automatic test_lap_on_tick();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);          // cycle 1
        step(49);                         // cycle 50: tick cycle, live 0:00.4
        pulse(1'b0, 1'b1, 1'b0);          // cycle 51
        checks++;
        if (disp !== tv(0,0,0,4) || stat !== 3'b110) begin
            failures++; $display("FAIL lap_on_tick got=%h/%b exp=%h/%b", disp, stat, tv(0,0,0,4), 3'b110);
        end
    endtask

    task automatic test_coincident();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);          // cycle 1
        step(15);                         // cycle 16, live 0:00.1, prescaler mid-count
        pulse(1'b1, 1'b1, 1'b0);          // ss wins -> STOP
        checks++;
        if (disp !== tv(0,0,0,1) || stat !== 3'b000) begin
            failures++; $display("FAIL ss_lap_stop got=%h/%b exp=%h/%b", disp, stat, tv(0,0,0,1), 3'b000);
        end
        pulse(1'b0, 1'b1, 1'b1);          // lap ignored in STOP, zero -> IDLE
        checks++;
        if (disp !== tv(0,0,0,0) || stat !== 3'b000) begin
            failures++; $display("FAIL lap_zero_idle got=%h/%b exp=%h/%b", disp, stat, tv(0,0,0,0), 3'b000);
        end
        // prescaler must also have cleared: full PRESCALE latency again
        pulse(1'b1, 1'b0, 1'b0);
        step(9);
        checks++;
        if (disp !== tv(0,0,0,0)) begin failures++; $display("FAIL idle_pre_clear_c10 got=%h exp=%h", disp, tv(0,0,0,0)); end
        step(1);
        checks++;
        if (disp !== tv(0,0,0,1)) begin failures++; $display("FAIL idle_pre_clear_c11 got=%h exp=%h", disp, tv(0,0,0,1)); end
        // zero ignored in RUN
        pulse(1'b0, 1'b0, 1'b1);
        checks++;
        if (disp !== tv(0,0,0,1) || stat !== 3'b100) begin
            failures++; $display("FAIL zero_in_run got=%h/%b exp=%h/%b", disp, stat, tv(0,0,0,1), 3'b100);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        pulse(1'b1, 1'b0, 1'b0);          // cycle 1
        step(59);                         // cycle 60, live 0:00.5
        pulse(1'b0, 1'b1, 1'b0);          // cycle 61, LAP_RUN
        step(39);                         // cycle 100: tick at live 0:00.9
        checks++;
        if (disp !== tv(0,0,0,5) || stat !== 3'b110) begin
            failures++; $display("FAIL pre_clr_c100 got=%h/%b exp=%h/%b", disp, stat, tv(0,0,0,5), 3'b110);
        end
        clr = 1'b1; btn_ss = 1'b1;
        step(1);
        clr = 1'b0; btn_ss = 1'b0;
        checks++;
        if (disp !== tv(0,0,0,0) || stat !== 3'b000) begin
            failures++; $display("FAIL clr_mid got=%h/%b exp=%h/%b", disp, stat, tv(0,0,0,0), 3'b000);
        end
        // live digits cleared too: leaving lap display would show them
        pulse(1'b1, 1'b0, 1'b0);
        checks++;
        if (disp !== tv(0,0,0,0) || stat !== 3'b100) begin
            failures++; $display("FAIL clr_mid_restart got=%h/%b exp=%h/%b", disp, stat, tv(0,0,0,0), 3'b100);
        end
    endtask

    task automatic test_wrap();
        clr_w = 1'b1;
        step(1);
        clr_w = 1'b0;
        pulse_w(1'b1, 1'b0, 1'b0);        // cycle 1; tick every even cycle
        step(11998);                      // cycle 11999, 5999 ticks
        checks++;
        if (disp_w !== tv(9,5,9,9) || stat_w !== 3'b100) begin
            failures++; $display("FAIL wrap_pre got=%h/%b exp=%h/%b", disp_w, stat_w, tv(9,5,9,9), 3'b100);
        end
        step(2);                          // cycle 12001, after the wrapping tick
`ifdef STOPWATCH_OVF_HALT_EN
        checks++;
        if (disp_w !== tv(9,5,9,9) || stat_w !== 3'b001) begin
            failures++; $display("FAIL halt_sat got=%h/%b exp=%h/%b", disp_w, stat_w, tv(9,5,9,9), 3'b001);
        end
        pulse_w(1'b1, 1'b0, 1'b0);
        step(3);
        checks++;
        if (disp_w !== tv(9,5,9,9) || stat_w !== 3'b001) begin
            failures++; $display("FAIL halt_ss_ignored got=%h/%b exp=%h/%b", disp_w, stat_w, tv(9,5,9,9), 3'b001);
        end
`else
        checks++;
        if (disp_w !== tv(0,0,0,0) || stat_w !== 3'b101) begin
            failures++; $display("FAIL wrap_zero got=%h/%b exp=%h/%b", disp_w, stat_w, tv(0,0,0,0), 3'b101);
        end
        pulse_w(1'b1, 1'b0, 1'b0);        // STOP, ovf stays
        checks++;
        if (stat_w !== 3'b001) begin failures++; $display("FAIL wrap_stop got=%b exp=%b", stat_w, 3'b001); end
`endif
        pulse_w(1'b0, 1'b0, 1'b1);        // zero -> IDLE
        checks++;
        if (disp_w !== tv(0,0,0,0) || stat_w !== 3'b000) begin
            failures++; $display("FAIL wrap_zero_idle got=%h/%b exp=%h/%b", disp_w, stat_w, tv(0,0,0,0), 3'b000);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_basic_count();
        test_pause_resume();
        test_lap_freeze();
        test_lap_on_tick();
        test_coincident();
        test_reset_mid();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
